alu_issue_scheduler: RTL and testbench
======================================

// Module: alu_issue_scheduler
// PURPOSE
//  Reservation-station scheduler that owns the single shared combinational ALU of the dynamic pipeline.
//  Accepts dispatched ALU ops whose operands may still be pending, wakes them on CDB broadcasts,
//  and issues the oldest ready op to the ALU. Registers the result and hands it to the CDB arbiter
//  over a valid/ready handshake.
// PARAMETERS
//  DEPTH  4   number of station entries (2..8)
//  TAG_W  4   producer/destination tag width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  flush        in   1      synchronous squash of all entries and the output register
//  disp_valid   in   1      dispatch request
//  disp_ready   out  1      station can accept (count < DEPTH)
//  disp_aluc    in   6      ALU opcode, codes as defined in alu_pkg
//  disp_a       in   32     operand A value (valid when disp_a_rdy)
//  disp_a_rdy   in   1      operand A present
//  disp_a_tag   in   TAG_W  producer tag of A when not ready
//  disp_b       in   32     operand B value (valid when disp_b_rdy)
//  disp_b_rdy   in   1      operand B present
//  disp_b_tag   in   TAG_W  producer tag of B when not ready
//  disp_dst     in   TAG_W  destination tag of this op
//  cdb_valid    in   1      CDB broadcast valid
//  cdb_tag      in   TAG_W  CDB broadcast tag
//  cdb_data     in   32     CDB broadcast value
//  alu_a        out  32     to ALU a (shift amount for shift ops)
//  alu_b        out  32     to ALU b
//  alu_aluc     out  6      to ALU aluc
//  alu_r        in   32     from ALU r (combinational, same cycle)
//  alu_zero     in   1      from ALU zero
//  res_valid    out  1      result register holds a result
//  res_ready    in   1      CDB arbiter accepts the result
//  res_tag      out  TAG_W  destination tag of the result
//  res_data     out  32     result value
//  res_zero     out  1      registered ALU zero flag
// BEHAVIOUR
//  Reset (async, rst_n=0): all entries invalid, count=0, res_valid=0, res_tag=0, res_data=0, res_zero=0.
//   alu_* = 0 while no issue; disp_ready=1 after reset.
//  Storage: collapsing queue. Entry 0 is oldest. Each entry holds v, aluc, a/a_rdy/a_tag, b/b_rdy/b_tag, dst.
//  Dispatch: accepted when disp_valid & disp_ready. The op is written at the tail after this cycle's compaction.
//   disp_ready depends on registered count only; no credit is taken for a same-cycle issue.
//  Wakeup: a valid entry with !x_rdy and x_tag==cdb_tag while cdb_valid captures cdb_data into x and sets x_rdy.
//   Dispatch bypass: an incoming !disp_x_rdy with disp_x_tag==cdb_tag while cdb_valid is written as ready with cdb_data.
//   An operand readied by the CDB is issue-eligible from the next cycle.
//  Issue select: lowest-index valid entry with a_rdy & b_rdy.
//   Issue is allowed when (!res_valid | res_ready) & !flush.
//  Issue cycle N:
//   - drive alu_a/alu_b/alu_aluc from the selected entry;
//   - capture alu_r, alu_zero and dst into the result register at the clock edge;
//   - res_valid=1 in cycle N+1, so issue-to-result latency is 1 cycle;
//   - remove the entry; entries above it shift down one slot.
//  Back-to-back: when res_ready=1, one issue per cycle. When res_valid & !res_ready, the result register
//   and all outputs hold stable and no issue occurs.
//  Opcodes: aluc is passed through unchanged; no decode. An unsupported code gives an undefined result but
//   is still retired normally.
//  Flush: next edge clears all entries, count and res_valid. A dispatch or issue in the flush cycle is discarded.
//   Flush has priority over every other event.
//  Reset mid-operation: immediate clear. No result is emitted for in-flight ops.
//  Full: count==DEPTH gives disp_ready=0. A full station that issues reopens disp_ready the next cycle.
//  Simultaneous events:
//   - the same entry can be woken and compacted in one cycle; the woken value moves with it;
//   - a CDB tag matching both operands of one entry fills both.
//  Invariant: count never exceeds DEPTH or underflows. Order among non-issued entries is preserved.
// STRUCTURE
//  Shared package alu_pkg:
//   - aluc localparams (ADD=6'b100000 ... SLTU=6'b101011, SLL=6'b000000 ... SRAV=6'b000111, LUI=6'b001111);
//   - TAG_W default;
//   - entry field widths.
//  Sub-module alu_rs_entry (one per slot): operand capture, CDB compare and ready logic.
//   The top level holds the compaction muxes, the oldest-ready priority select and the result register.
// TESTING
//  1 Ready op: dispatch ADD a=5 b=7 dst=3, both ready, res_ready=1 -> alu_aluc=6'b100000 in the next cycle,
//    then res_valid=1, res_data=12, res_tag=3, res_zero=0.
//  2 Wakeup: dispatch SUB dst=1 with b pending on tag 9, then cdb(9,20) with a=20 -> issues one cycle after
//    the CDB, res_data=0, res_zero=1.
//  3 Age order: dispatch op0 (b waits tag 2), op1 ready, op2 ready -> op1 issues, then op2.
//    cdb tag 2 then op0 issues; the remaining order is kept.
//  4 Backpressure and full: res_ready=0, dispatch 5 ready ops (DEPTH=4):
//    - one op moves to the result register, 4 remain, disp_ready=0, res_data holds;
//    - raise res_ready -> one result per cycle, in order.
//  5 Bypass: disp_a_rdy=0 with disp_a_tag==cdb_tag=4 in the same cycle, cdb_data=0x10, SLL b=1
//    -> res_data=0x00010000.
//  6 Flush/reset: 3 entries plus a held result, then flush=1 for 1 cycle -> count=0, res_valid=0, disp_ready=1.
//    Pulse rst_n low mid-issue -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU reservation station: opcode codes,
// datapath widths and the default tag width.
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int ALUC_W    = 6;
    localparam int TAG_W_DEF = 4;

    // ALU opcodes; the scheduler passes them through untouched.
    localparam logic [ALUC_W-1:0] ALUC_ADD  = 6'b100000;
    localparam logic [ALUC_W-1:0] ALUC_ADDU = 6'b100001;
    localparam logic [ALUC_W-1:0] ALUC_SUB  = 6'b100010;
    localparam logic [ALUC_W-1:0] ALUC_SUBU = 6'b100011;
    localparam logic [ALUC_W-1:0] ALUC_AND  = 6'b100100;
    localparam logic [ALUC_W-1:0] ALUC_OR   = 6'b100101;
    localparam logic [ALUC_W-1:0] ALUC_XOR  = 6'b100110;
    localparam logic [ALUC_W-1:0] ALUC_NOR  = 6'b100111;
    localparam logic [ALUC_W-1:0] ALUC_SLT  = 6'b101010;
    localparam logic [ALUC_W-1:0] ALUC_SLTU = 6'b101011;
    localparam logic [ALUC_W-1:0] ALUC_SLL  = 6'b000000;
    localparam logic [ALUC_W-1:0] ALUC_SRL  = 6'b000010;
    localparam logic [ALUC_W-1:0] ALUC_SRA  = 6'b000011;
    localparam logic [ALUC_W-1:0] ALUC_SLLV = 6'b000100;
    localparam logic [ALUC_W-1:0] ALUC_SRLV = 6'b000110;
    localparam logic [ALUC_W-1:0] ALUC_SRAV = 6'b000111;
    localparam logic [ALUC_W-1:0] ALUC_LUI  = 6'b001111;

endpackage

// File: rtl/alu_rs_entry.sv
// One reservation-station slot. The top level decides whether the slot
// keeps its contents or loads new ones (shift from the slot above, or a
// dispatch). Whatever is kept or loaded is then snooped against the CDB,
// so a value woken in the same cycle it moves travels with the op.
module alu_rs_entry
    import alu_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              src_v_i,
    input  logic [ALUC_W-1:0] src_aluc_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic              src_a_rdy_i,
    input  logic [TAG_W-1:0]  src_a_tag_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              src_b_rdy_i,
    input  logic [TAG_W-1:0]  src_b_tag_i,
    input  logic [TAG_W-1:0]  src_dst_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic              v_o,
    output logic [ALUC_W-1:0] aluc_o,
    output logic [DATA_W-1:0] a_o,
    output logic              a_rdy_o,
    output logic [TAG_W-1:0]  a_tag_o,
    output logic [DATA_W-1:0] b_o,
    output logic              b_rdy_o,
    output logic [TAG_W-1:0]  b_tag_o,
    output logic [TAG_W-1:0]  dst_o,
    output logic              rdy_o
);

    logic              v_q, v_d;
    logic [ALUC_W-1:0] aluc_q, aluc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
    logic [TAG_W-1:0]  a_tag_q, a_tag_d, b_tag_q, b_tag_d, dst_q, dst_d;
    logic              a_hit, b_hit;

    // Pick kept-or-loaded contents, then fill any operand the CDB is broadcasting.
    always_comb begin
        v_d     = load_i ? src_v_i     : v_q;
        aluc_d  = load_i ? src_aluc_i  : aluc_q;
        a_d     = load_i ? src_a_i     : a_q;
        a_rdy_d = load_i ? src_a_rdy_i : a_rdy_q;
        a_tag_d = load_i ? src_a_tag_i : a_tag_q;
        b_d     = load_i ? src_b_i     : b_q;
        b_rdy_d = load_i ? src_b_rdy_i : b_rdy_q;
        b_tag_d = load_i ? src_b_tag_i : b_tag_q;
        dst_d   = load_i ? src_dst_i   : dst_q;
        a_hit   = v_d & !a_rdy_d & cdb_valid_i & (a_tag_d == cdb_tag_i);
        b_hit   = v_d & !b_rdy_d & cdb_valid_i & (b_tag_d == cdb_tag_i);
        if (a_hit) begin
            a_d     = cdb_data_i;
            a_rdy_d = 1'b1;
        end
        if (b_hit) begin
            b_d     = cdb_data_i;
            b_rdy_d = 1'b1;
        end
        if (clr_i) begin
            v_d = 1'b0;
        end
    end

    // Slot storage; a squash only needs to drop the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= 1'b0;
            aluc_q  <= '0;
            a_q     <= '0;
            a_rdy_q <= 1'b0;
            a_tag_q <= '0;
            b_q     <= '0;
            b_rdy_q <= 1'b0;
            b_tag_q <= '0;
            dst_q   <= '0;
        end else begin
            v_q     <= v_d;
            aluc_q  <= aluc_d;
            a_q     <= a_d;
            a_rdy_q <= a_rdy_d;
            a_tag_q <= a_tag_d;
            b_q     <= b_d;
            b_rdy_q <= b_rdy_d;
            b_tag_q <= b_tag_d;
            dst_q   <= dst_d;
        end
    end

    assign v_o     = v_q;
    assign aluc_o  = aluc_q;
    assign a_o     = a_q;
    assign a_rdy_o = a_rdy_q;
    assign a_tag_o = a_tag_q;
    assign b_o     = b_q;
    assign b_rdy_o = b_rdy_q;
    assign b_tag_o = b_tag_q;
    assign dst_o   = dst_q;
    // Registered readiness: an operand woken this cycle makes the op eligible next cycle.
    assign rdy_o   = v_q & a_rdy_q & b_rdy_q;

endmodule

// File: rtl/alu_issue_scheduler.sv
// Reservation station in front of the shared combinational ALU.
// Collapsing queue (slot 0 oldest), oldest-ready issue, one registered
// result handed to the CDB arbiter.
// Result handshake: a result transfers on a cycle where res_valid and
// res_ready are both high; while res_valid is high and res_ready low, the
// result outputs hold and nothing issues.
module alu_issue_scheduler
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [ALUC_W-1:0] disp_aluc,
    input  logic [DATA_W-1:0] disp_a,
    input  logic              disp_a_rdy,
    input  logic [TAG_W-1:0]  disp_a_tag,
    input  logic [DATA_W-1:0] disp_b,
    input  logic              disp_b_rdy,
    input  logic [TAG_W-1:0]  disp_b_tag,
    input  logic [TAG_W-1:0]  disp_dst,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [ALUC_W-1:0] alu_aluc,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TAG_W-1:0]  res_tag,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero
);

    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Current slot contents.
    logic              ent_v     [DEPTH];
    logic [ALUC_W-1:0] ent_aluc  [DEPTH];
    logic [DATA_W-1:0] ent_a     [DEPTH];
    logic              ent_a_rdy [DEPTH];
    logic [TAG_W-1:0]  ent_a_tag [DEPTH];
    logic [DATA_W-1:0] ent_b     [DEPTH];
    logic              ent_b_rdy [DEPTH];
    logic [TAG_W-1:0]  ent_b_tag [DEPTH];
    logic [TAG_W-1:0]  ent_dst   [DEPTH];
    logic              ent_rdy   [DEPTH];

    // Per-slot load source chosen by the compaction logic.
    logic              load      [DEPTH];
    logic              src_v     [DEPTH];
    logic [ALUC_W-1:0] src_aluc  [DEPTH];
    logic [DATA_W-1:0] src_a     [DEPTH];
    logic              src_a_rdy [DEPTH];
    logic [TAG_W-1:0]  src_a_tag [DEPTH];
    logic [DATA_W-1:0] src_b     [DEPTH];
    logic              src_b_rdy [DEPTH];
    logic [TAG_W-1:0]  src_b_tag [DEPTH];
    logic [TAG_W-1:0]  src_dst   [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d, base;
    logic [SEL_W-1:0]  sel;
    logic              any_rdy, issue_ok, issue, accept;
    logic              res_valid_q, res_zero_q;
    logic [TAG_W-1:0]  res_tag_q;
    logic [DATA_W-1:0] res_data_q;

    // No credit for a same-cycle issue: only the registered count gates dispatch.
    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign accept     = disp_valid & disp_ready;
    assign issue_ok   = (!res_valid_q | res_ready) & !flush;
    assign issue      = issue_ok & any_rdy;
    // Tail position once this cycle's issue has collapsed the queue.
    assign base       = count_q - CNT_W'(issue);

    // Oldest-ready priority select: the lowest ready slot wins.
    always_comb begin
        any_rdy = 1'b0;
        sel     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_rdy[i]) begin
                any_rdy = 1'b1;
                sel     = SEL_W'(i);
            end
        end
    end

    // Compaction: slots at and above the issued one shift down, dispatch lands at the new tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int up;
            up           = (i < DEPTH - 1) ? i + 1 : i;
            load[i]      = 1'b0;
            src_v[i]     = 1'b0;
            src_aluc[i]  = '0;
            src_a[i]     = '0;
            src_a_rdy[i] = 1'b0;
            src_a_tag[i] = '0;
            src_b[i]     = '0;
            src_b_rdy[i] = 1'b0;
            src_b_tag[i] = '0;
            src_dst[i]   = '0;
            if (accept && (base == CNT_W'(i))) begin
                load[i]      = 1'b1;
                src_v[i]     = 1'b1;
                src_aluc[i]  = disp_aluc;
                src_a[i]     = disp_a;
                src_a_rdy[i] = disp_a_rdy;
                src_a_tag[i] = disp_a_tag;
                src_b[i]     = disp_b;
                src_b_rdy[i] = disp_b_rdy;
                src_b_tag[i] = disp_b_tag;
                src_dst[i]   = disp_dst;
            end else if (issue && (i >= int'(sel))) begin
                load[i]      = 1'b1;
                src_v[i]     = (i < DEPTH - 1) && ent_v[up];
                src_aluc[i]  = ent_aluc[up];
                src_a[i]     = ent_a[up];
                src_a_rdy[i] = ent_a_rdy[up];
                src_a_tag[i] = ent_a_tag[up];
                src_b[i]     = ent_b[up];
                src_b_rdy[i] = ent_b_rdy[up];
                src_b_tag[i] = ent_b_tag[up];
                src_dst[i]   = ent_dst[up];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        alu_rs_entry #(.TAG_W(TAG_W)) u_ent (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_i       (flush),
            .load_i      (load[g]),
            .src_v_i     (src_v[g]),
            .src_aluc_i  (src_aluc[g]),
            .src_a_i     (src_a[g]),
            .src_a_rdy_i (src_a_rdy[g]),
            .src_a_tag_i (src_a_tag[g]),
            .src_b_i     (src_b[g]),
            .src_b_rdy_i (src_b_rdy[g]),
            .src_b_tag_i (src_b_tag[g]),
            .src_dst_i   (src_dst[g]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .v_o         (ent_v[g]),
            .aluc_o      (ent_aluc[g]),
            .a_o         (ent_a[g]),
            .a_rdy_o     (ent_a_rdy[g]),
            .a_tag_o     (ent_a_tag[g]),
            .b_o         (ent_b[g]),
            .b_rdy_o     (ent_b_rdy[g]),
            .b_tag_o     (ent_b_tag[g]),
            .dst_o       (ent_dst[g]),
            .rdy_o       (ent_rdy[g])
        );
    end

    // Drive the ALU only in an issue cycle; idle value is all zeros.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_aluc = '0;
        if (issue) begin
            alu_a    = ent_a[sel];
            alu_b    = ent_b[sel];
            alu_aluc = ent_aluc[sel];
        end
    end

    // Occupancy next state; a flush empties the station regardless of other events.
    always_comb begin
        count_d = count_q - CNT_W'(issue) + CNT_W'(accept);
        if (flush) begin
            count_d = '0;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Result register: capture on issue, drop on acceptance, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
        end else if (flush) begin
            res_valid_q <= 1'b0;
        end else if (issue) begin
            res_valid_q <= 1'b1;
            res_tag_q   <= ent_dst[sel];
            res_data_q  <= alu_r;
            res_zero_q  <= alu_zero;
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler with a behavioural ALU attached.
module tb_alu_issue_scheduler;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [5:0]  disp_aluc;
    logic [31:0] disp_a;
    logic        disp_a_rdy;
    logic [3:0]  disp_a_tag;
    logic [31:0] disp_b;
    logic        disp_b_rdy;
    logic [3:0]  disp_b_tag;
    logic [3:0]  disp_dst;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_aluc;
    logic [31:0] alu_r;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_tag;
    logic [31:0] res_data;
    logic        res_zero;

    int n_cmp;
    int n_err;

    alu_issue_scheduler #(.DEPTH(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_aluc  (disp_aluc),
        .disp_a     (disp_a),
        .disp_a_rdy (disp_a_rdy),
        .disp_a_tag (disp_a_tag),
        .disp_b     (disp_b),
        .disp_b_rdy (disp_b_rdy),
        .disp_b_tag (disp_b_tag),
        .disp_dst   (disp_dst),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_aluc   (alu_aluc),
        .alu_r      (alu_r),
        .alu_zero   (alu_zero),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_tag    (res_tag),
        .res_data   (res_data),
        .res_zero   (res_zero)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU (shift amount comes from a).
    function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALUC_ADD, ALUC_ADDU: return a + b;
            ALUC_SUB, ALUC_SUBU: return a - b;
            ALUC_AND:            return a & b;
            ALUC_OR:             return a | b;
            ALUC_XOR:            return a ^ b;
            ALUC_NOR:            return ~(a | b);
            ALUC_SLT:            return {31'b0, $signed(a) < $signed(b)};
            ALUC_SLTU:           return {31'b0, a < b};
            ALUC_SLL, ALUC_SLLV: return b << a[4:0];
            ALUC_SRL, ALUC_SRLV: return b >> a[4:0];
            ALUC_SRA, ALUC_SRAV: return $signed(b) >>> a[4:0];
            ALUC_LUI:            return {b[15:0], 16'h0000};
            default:             return 32'h0;
        endcase
    endfunction

    always_comb begin
        alu_r    = alu_model(alu_aluc, alu_a, alu_b);
        alu_zero = (alu_r == 32'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one dispatch for one clock edge.
    task automatic disp_op(input logic [5:0] op, input logic [31:0] a, input logic a_rdy, input logic [3:0] a_tag,
                           input logic [31:0] b, input logic b_rdy, input logic [3:0] b_tag, input logic [3:0] dst);
        disp_aluc  = op;
        disp_a     = a;
        disp_a_rdy = a_rdy;
        disp_a_tag = a_tag;
        disp_b     = b;
        disp_b_rdy = b_rdy;
        disp_b_tag = b_tag;
        disp_dst   = dst;
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_aluc  = '0;
        disp_a     = '0;
        disp_a_rdy = 1'b0;
        disp_a_tag = '0;
        disp_b     = '0;
        disp_b_rdy = 1'b0;
        disp_b_tag = '0;
        disp_dst   = '0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_data   = '0;
        res_ready  = 1'b1;

        // Reset values
        #3;
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_tag", {28'b0, res_tag}, 32'd0);
        chk("rst_res_zero", {31'b0, res_zero}, 32'd0);
        chk("rst_alu_aluc", {26'b0, alu_aluc}, 32'd0);
        #14;
        rst_n = 1'b1;
        chk("rst_disp_ready", {31'b0, disp_ready}, 32'd1);
        tick();

        // 1: ready ADD 5+7 -> dst 3
        disp_op(ALUC_ADD, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
        #1;
        chk("t1_alu_aluc", {26'b0, alu_aluc}, {26'b0, ALUC_ADD});
        chk("t1_alu_a", alu_a, 32'd5);
        chk("t1_alu_b", alu_b, 32'd7);
        chk("t1_res_valid_pre", {31'b0, res_valid}, 32'd0);
        tick();
        chk("t1_res_valid", {31'b0, res_valid}, 32'd1);
        chk("t1_res_data", res_data, 32'd12);
        chk("t1_res_tag", {28'b0, res_tag}, 32'd3);
        chk("t1_res_zero", {31'b0, res_zero}, 32'd0);
        chk("t1_idle_aluc", {26'b0, alu_aluc}, 32'd0);
        tick();
        chk("t1_drained", {31'b0, res_valid}, 32'd0);

        // 2: SUB with b waiting on tag 9, woken by cdb(9,20)
        disp_op(ALUC_SUB, 32'd20, 1'b1, 4'd0, 32'd0, 1'b0, 4'd9, 4'd1);
        #1;
        chk("t2_wait_aluc", {26'b0, alu_aluc}, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd20;
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("t2_issue_aluc", {26'b0, alu_aluc}, {26'b0, ALUC_SUB});
        chk("t2_issue_b", alu_b, 32'd20);
        tick();
        chk("t2_res_data", res_data, 32'd0);
        chk("t2_res_zero", {31'b0, res_zero}, 32'd1);
        chk("t2_res_tag", {28'b0, res_tag}, 32'd1);
        tick();

        // 3: age order, oldest op blocked on tag 2
        disp_op(ALUC_ADD, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd2, 4'd4);
        #1;
        chk("t3_op0_blocked", {26'b0, alu_aluc}, 32'd0);
        disp_op(ALUC_ADD, 32'd2, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 4'd5);
        #1;
        chk("t3_op1_issue_a", alu_a, 32'd2);
        disp_op(ALUC_XOR, 32'hF0, 1'b1, 4'd0, 32'h0F, 1'b1, 4'd0, 4'd6);
        #1;
        chk("t3_op1_res_tag", {28'b0, res_tag}, 32'd5);
        chk("t3_op1_res_data", res_data, 32'd5);
        chk("t3_op2_issue_a", alu_a, 32'hF0);
        tick();
        chk("t3_op2_res_tag", {28'b0, res_tag}, 32'd6);
        chk("t3_op2_res_data", res_data, 32'hFF);
        chk("t3_op0_still_blocked", {26'b0, alu_aluc}, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'd10;
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("t3_op0_issue_a", alu_a, 32'd1);
        chk("t3_op0_issue_b", alu_b, 32'd10);
        tick();
        chk("t3_op0_res_tag", {28'b0, res_tag}, 32'd4);
        chk("t3_op0_res_data", res_data, 32'd11);
        tick();
        chk("t3_drained", {31'b0, res_valid}, 32'd0);

        // 4: backpressure and full station
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            disp_op(ALUC_ADD, 32'(k), 1'b1, 4'd0, 32'd100, 1'b1, 4'd0, 4'(8 + k));
        end
        #1;
        chk("t4_full_disp_ready", {31'b0, disp_ready}, 32'd0);
        chk("t4_held_valid", {31'b0, res_valid}, 32'd1);
        chk("t4_held_data", res_data, 32'd100);
        chk("t4_held_tag", {28'b0, res_tag}, 32'd8);
        chk("t4_no_issue", {26'b0, alu_aluc}, 32'd0);
        disp_op(ALUC_ADD, 32'h55, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd15);
        #1;
        chk("t4_still_full", {31'b0, disp_ready}, 32'd0);
        chk("t4_still_held", res_data, 32'd100);
        res_ready = 1'b1;
        #1;
        chk("t4_op1_issue_a", alu_a, 32'd1);
        tick();
        chk("t4_op1_res_data", res_data, 32'd101);
        chk("t4_op1_res_tag", {28'b0, res_tag}, 32'd9);
        chk("t4_reopen", {31'b0, disp_ready}, 32'd1);
        for (int k = 2; k < 5; k++) begin
            tick();
            chk("t4_stream_data", res_data, 32'(100 + k));
        end
        tick();
        chk("t4_no_refused_op", {31'b0, res_valid}, 32'd0);

        // 5: dispatch bypass on operand a, SLL b=1 by 0x10
        cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_data = 32'h10;
        disp_op(ALUC_SLL, 32'd0, 1'b0, 4'd4, 32'd1, 1'b1, 4'd0, 4'd7);
        cdb_valid = 1'b0;
        #1;
        chk("t5_issue_a", alu_a, 32'h10);
        chk("t5_issue_b", alu_b, 32'd1);
        tick();
        chk("t5_res_data", res_data, 32'h0001_0000);
        chk("t5_res_tag", {28'b0, res_tag}, 32'd7);
        tick();

        // 7: wake while compacting, one tag filling both operands
        res_ready = 1'b0;
        disp_op(ALUC_ADD, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd12);
        disp_op(ALUC_ADD, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd10);
        disp_op(ALUC_ADD, 32'd0, 1'b0, 4'd5, 32'd0, 1'b0, 4'd5, 4'd11);
        #1;
        chk("t7_blocked_aluc", {26'b0, alu_aluc}, 32'd0);
        chk("t7_held_data", res_data, 32'd7);
        res_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd7;
        #1;
        chk("t7_opA_issue_a", alu_a, 32'd1);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("t7_opA_res_tag", {28'b0, res_tag}, 32'd10);
        chk("t7_opA_res_data", res_data, 32'd2);
        chk("t7_opB_issue_a", alu_a, 32'd7);
        chk("t7_opB_issue_b", alu_b, 32'd7);
        tick();
        chk("t7_opB_res_tag", {28'b0, res_tag}, 32'd11);
        chk("t7_opB_res_data", res_data, 32'd14);
        tick();

        // 6a: flush with three entries and a held result
        res_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            disp_op(ALUC_ADD, 32'(k), 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'(k));
        end
        #1;
        chk("t6_held_before_flush", {31'b0, res_valid}, 32'd1);
        flush = 1'b1;
        disp_op(ALUC_ADD, 32'd9, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 4'd9);
        flush = 1'b0;
        #1;
        chk("t6_flush_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t6_flush_disp_ready", {31'b0, disp_ready}, 32'd1);
        chk("t6_flush_no_issue", {26'b0, alu_aluc}, 32'd0);
        res_ready = 1'b1;
        tick();
        tick();
        chk("t6_empty_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t6_empty_no_issue", {26'b0, alu_aluc}, 32'd0);

        // 6b: asynchronous reset mid-issue
        disp_op(ALUC_ADD, 32'd6, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 4'd13);
        disp_op(ALUC_ADD, 32'd8, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 4'd14);
        #1;
        chk("t6_pre_rst_data", res_data, 32'd12);
        chk("t6_pre_rst_issue_a", alu_a, 32'd8);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t6_rst_res_data", res_data, 32'd0);
        chk("t6_rst_res_tag", {28'b0, res_tag}, 32'd0);
        chk("t6_rst_alu_aluc", {26'b0, alu_aluc}, 32'd0);
        chk("t6_rst_alu_a", alu_a, 32'd0);
        chk("t6_rst_disp_ready", {31'b0, disp_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t6_post_rst_quiet1", {31'b0, res_valid}, 32'd0);
        tick();
        chk("t6_post_rst_quiet2", {31'b0, res_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
